// File: rtl/plus_operator_adder.sv
// Reference adder: Sum = A + B + Cin with unsigned carry-out and signed overflow,
// offered both combinationally and through a one-cycle registered path with valid.
module plus_operator_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [WIDTH:0]   result;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             out_valid_d;
  logic             out_valid_q;

  always_comb begin
    result = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    Sum    = result[MSB:0];
    Cout   = result[WIDTH];
    Ovf    = signed_ovf(A[MSB], B[MSB], result[MSB]);
  end

  // Capture stage: load on in_valid, otherwise hold the last result.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = Sum;
      cout_d = Cout;
      ovf_d  = Ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_plus_operator_adder.sv
// Directed bench for plus_operator_adder: combinational vectors, registered
// streaming/hold behaviour and asynchronous reset.
module tb_plus_operator_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic        Cin, in_valid;
  logic [31:0] Sum, sum_q;
  logic        Cout, Ovf, cout_q, ovf_q, out_valid;

  int passed = 0;
  int total  = 0;

  plus_operator_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .in_valid(in_valid),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf),
    .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_comb(input string tag, input logic [31:0] es,
                          input logic ec, input logic eo);
    chk({tag, ".Sum"},  Sum,  es);
    chk({tag, ".Cout"}, {31'b0, Cout}, {31'b0, ec});
    chk({tag, ".Ovf"},  {31'b0, Ovf},  {31'b0, eo});
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] es, input logic ec,
                         input logic eo, input logic ev);
    chk({tag, ".sum_q"},     sum_q, es);
    chk({tag, ".cout_q"},    {31'b0, cout_q},    {31'b0, ec});
    chk({tag, ".ovf_q"},     {31'b0, ovf_q},     {31'b0, eo});
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ev});
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic v);
    A = a; B = b; Cin = c; in_valid = v;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_reg("reset", 32'h0, 1'b0, 1'b0, 1'b0);

    @(negedge clk) rst_n = 1'b1;

    // First registered transaction: positive overflow
    drive(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
    #1 chk_comb("pos_ovf", 32'h80000000, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_reg("pos_ovf_reg", 32'h80000000, 1'b0, 1'b1, 1'b1);

    // Combinational vectors with in_valid low
    @(negedge clk);
    drive(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0); #1 chk_comb("neg_ovf",  32'h7FFFFFFF, 1'b1, 1'b1);
    drive(32'd100, 32'hFFFFFF38, 1'b0, 1'b0);      #1 chk_comb("mixed",    32'hFFFFFF9C, 1'b0, 1'b0);
    drive(32'd50, 32'd100, 1'b0, 1'b0);            #1 chk_comb("small",    32'd150,      1'b0, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0);               #1 chk_comb("zero",     32'd0,        1'b0, 1'b0);
    drive(32'hFFFFFFCE, 32'hFFFFFF9C, 1'b1, 1'b0); #1 chk_comb("negneg",   32'hFFFFFF6B, 1'b1, 1'b0);
    drive(32'd1234, 32'hFFFFE9D2, 1'b1, 1'b0);     #1 chk_comb("cin_mix",  32'hFFFFEEA5, 1'b0, 1'b0);
    drive(32'hFFFFD96C, 32'd5432, 1'b0, 1'b0);     #1 chk_comb("neg_pos",  32'hFFFFEEA4, 1'b0, 1'b0);
    drive(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);        #1 chk_comb("wrap",     32'h0,        1'b1, 1'b0);
    drive(32'h7FFFFFFF, 32'd0, 1'b1, 1'b0);        #1 chk_comb("cin_ovf",  32'h80000000, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_reg("hold_idle", 32'h80000000, 1'b0, 1'b1, 1'b0);

    // Three back-to-back valid sets
    @(negedge clk) drive(32'd5, 32'd10, 1'b0, 1'b1);
    @(posedge clk); #1 chk_reg("stream1", 32'd15, 1'b0, 1'b0, 1'b1);
    @(negedge clk) drive(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
    @(posedge clk); #1 chk_reg("stream2", 32'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk) drive(32'h80000000, 32'h80000000, 1'b1, 1'b1);
    @(posedge clk); #1 chk_reg("stream3", 32'd1, 1'b1, 1'b1, 1'b1);
    @(negedge clk) drive(32'd7, 32'd8, 1'b0, 1'b0);
    @(posedge clk); #1 chk_reg("after1", 32'd1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1 chk_reg("after2", 32'd1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges discards the in-flight result
    @(negedge clk) drive(32'd3, 32'd4, 1'b0, 1'b1);
    @(posedge clk); #1 chk_reg("pre_rst", 32'd7, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reg("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk_comb("comb_in_rst", 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1 chk_reg("held_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) begin rst_n = 1'b1; drive(32'd2, 32'd2, 1'b0, 1'b1); end
    @(posedge clk); #1 chk_reg("post_rst", 32'd4, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
